// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared constants and address decode for the mem_bus slice.
//   - MMIO register addresses (base 0xF0; everything below it is RAM)
//   - STATUS and TIMER_CTRL bit positions
//   - sel_t / decode(): maps a byte address to the target it selects
package mem_bus_pkg;

  localparam logic [7:0] MMIO_BASE      = 8'hF0;
  localparam logic [7:0] ADR_OUT_DATA   = 8'hF0;
  localparam logic [7:0] ADR_STATUS     = 8'hF1;
  localparam logic [7:0] ADR_TIMER_LO   = 8'hF2;
  localparam logic [7:0] ADR_TIMER_HI   = 8'hF3;
  localparam logic [7:0] ADR_TIMER_CTRL = 8'hF4;

  // STATUS register layout
  localparam int unsigned ST_FULL     = 0;
  localparam int unsigned ST_EMPTY    = 1;
  localparam int unsigned ST_COUNT_LO = 2;
  localparam int unsigned ST_COUNT_HI = 4;
  localparam int unsigned ST_OVERFLOW = 7;

  // TIMER_CTRL register layout
  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_CLR = 1;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_OUT_DATA,
    SEL_STATUS,
    SEL_TIMER_LO,
    SEL_TIMER_HI,
    SEL_TIMER_CTRL,
    SEL_NONE
  } sel_t;

  function automatic sel_t decode(input logic [7:0] a);
    sel_t s;
    if (a < MMIO_BASE) begin
      s = SEL_RAM;
    end else begin
      case (a)
        ADR_OUT_DATA:   s = SEL_OUT_DATA;
        ADR_STATUS:     s = SEL_STATUS;
        ADR_TIMER_LO:   s = SEL_TIMER_LO;
        ADR_TIMER_HI:   s = SEL_TIMER_HI;
        ADR_TIMER_CTRL: s = SEL_TIMER_CTRL;
        default:        s = SEL_NONE;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/mem_bus_out_fifo.sv
// out_fifo: small circular output FIFO feeding a valid/ready consumer.
//   clk, rst        : clock, asynchronous active-low reset
//   push, push_data : enqueue request and byte
//   pop             : consumer ready; only acts when the FIFO is non-empty
//   head            : oldest entry (0 while empty)
//   count           : number of stored entries, 0..FIFO_DEPTH
//   full, empty     : occupancy flags
//   overflow_pulse  : one-cycle flag for a push dropped because the FIFO is full
// FIFO_DEPTH must be a power of two (2..8) so the pointers wrap naturally.
module out_fifo #(
  parameter  int unsigned WIDTH      = 8,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PW         = $clog2(FIFO_DEPTH),
  localparam int unsigned CW         = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow_pulse
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;
  logic             do_push;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(FIFO_DEPTH));
  assign do_pop = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted; the write lands on the slot being vacated.
  assign do_push        = push && (!full || do_pop);
  assign overflow_pulse = push && full && !do_pop;

  // Storage is not reset, so gate the head to read zero while empty.
  assign head  = empty ? '0 : mem[rd_ptr];
  assign count = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_bus.sv
// mem_bus: RAM + MMIO subsystem behind the 8-bit multicycle MIPS core.
//   clk       : clock, all state updates on posedge
//   rst       : asynchronous active-low reset (RAM contents are kept)
//   adr       : byte address from the core
//   writedata : store data from the core
//   memread   : read strobe; only qualifies the TIMER_LO snapshot side effect
//   memwrite  : write strobe; writes commit at posedge
//   memdata   : combinational read data for adr
//   tx_data   : output FIFO head byte
//   tx_valid  : output FIFO non-empty
//   tx_ready  : consumer takes the head this cycle
// Map: 0x00-0xEF RAM, 0xF0 OUT_DATA, 0xF1 STATUS, 0xF2 TIMER_LO,
//      0xF3 TIMER_HI (snapshot), 0xF4 TIMER_CTRL, 0xF5-0xFF reserved (read 0).
module mem_bus
  import mem_bus_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMER_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             memread,
  input  logic             memwrite,
  output logic [WIDTH-1:0] memdata,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int unsigned RAM_BYTES = 240;
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;

  logic [WIDTH-1:0]      ram [RAM_BYTES];
  logic [TIMER_BITS-1:0] timer;
  logic [TIMER_BITS-9:0] snapshot;
  logic                  enable;
  logic                  overflow;

  sel_t                  sel;
  logic                  wr_ram;
  logic                  wr_out;
  logic                  wr_status;
  logic                  wr_ctrl;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_ovf;

  assign sel       = decode(8'(adr));
  assign wr_ram    = memwrite && (sel == SEL_RAM);
  assign wr_out    = memwrite && (sel == SEL_OUT_DATA);
  assign wr_status = memwrite && (sel == SEL_STATUS);
  assign wr_ctrl   = memwrite && (sel == SEL_TIMER_CTRL);

  out_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .push           (wr_out),
    .push_data      (writedata),
    .pop            (tx_ready),
    .head           (tx_data),
    .count          (fifo_count),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .overflow_pulse (fifo_ovf)
  );

  assign tx_valid = !fifo_empty;

  // RAM: no reset, write at posedge.
  always_ff @(posedge clk) begin
    if (wr_ram) ram[adr] <= writedata;
  end

  // Timer: clear beats increment; enable is taken from the same write, so
  // enable+clear yields 0 at this edge and counting from the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer  <= '0;
      enable <= 1'b0;
    end else begin
      if (wr_ctrl) enable <= writedata[CTRL_EN];
      if (wr_ctrl && writedata[CTRL_CLR]) timer <= '0;
      else if (enable)                    timer <= timer + TIMER_BITS'(1);
    end
  end

  // Reading TIMER_LO latches the high byte so a following TIMER_HI read
  // pairs with the low byte just seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot <= '0;
    end else if (memread && (sel == SEL_TIMER_LO)) begin
      snapshot <= timer[TIMER_BITS-1:8];
    end
  end

  // Sticky overflow; any STATUS write clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (fifo_ovf) begin
      overflow <= 1'b1;
    end else if (wr_status) begin
      overflow <= 1'b0;
    end
  end

  // Combinational read mux: pre-write values are visible during a write cycle.
  always_comb begin
    memdata = '0;
    case (sel)
      SEL_RAM:        memdata = ram[adr];
      SEL_STATUS: begin
        memdata[ST_FULL]                   = fifo_full;
        memdata[ST_EMPTY]                  = fifo_empty;
        memdata[ST_COUNT_HI:ST_COUNT_LO]   = 3'(fifo_count);
        memdata[ST_OVERFLOW]               = overflow;
      end
      SEL_TIMER_LO:   memdata = WIDTH'(timer[7:0]);
      SEL_TIMER_HI:   memdata = WIDTH'(snapshot);
      SEL_TIMER_CTRL: memdata[CTRL_EN] = enable;
      default:        memdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_bus.sv
module tb_mem_bus;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic       memread;
  logic       memwrite;
  logic [7:0] memdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_bus #(
    .WIDTH      (8),
    .FIFO_DEPTH (4),
    .TIMER_BITS (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .adr       (adr),
    .writedata (writedata),
    .memread   (memread),
    .memwrite  (memwrite),
    .memdata   (memdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // One bus cycle: set at negedge, commit at the following posedge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    adr = a; writedata = d; memwrite = 1'b1;
    @(posedge clk);
    #1 memwrite = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    adr = a; memread = 1'b1;
    #1 d = memdata;
    @(posedge clk);
    #1 memread = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %02h expected 00", tx_data); end
    adr = 8'hF1; #1;
    tests++; if (memdata !== 8'h02) begin fails++; $display("FAIL reset_status: got %02h expected 02", memdata); end
    adr = 8'hF2; #1;
    tests++; if (memdata !== 8'h00) begin fails++; $display("FAIL reset_timer_lo: got %02h expected 00", memdata); end
    adr = 8'hF3; #1;
    tests++; if (memdata !== 8'h00) begin fails++; $display("FAIL reset_snapshot: got %02h expected 00", memdata); end
    adr = 8'hF4; #1;
    tests++; if (memdata !== 8'h00) begin fails++; $display("FAIL reset_ctrl: got %02h expected 00", memdata); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ram();
    logic [7:0] d;
    wr(8'h10, 8'h5A);
    wr(8'hEF, 8'hA5);
    rd(8'h10, d);
    tests++; if (d !== 8'h5A) begin fails++; $display("FAIL ram_10: got %02h expected 5a", d); end
    rd(8'hEF, d);
    tests++; if (d !== 8'hA5) begin fails++; $display("FAIL ram_ef: got %02h expected a5", d); end
    wr(8'hF7, 8'hFF);
    rd(8'hF7, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL reserved_f7: got %02h expected 00", d); end
    rd(8'hF0, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL out_data_read: got %02h expected 00", d); end
    // read and write in the same cycle: old data visible, new data after edge
    wr(8'h40, 8'h12);
    @(negedge clk);
    adr = 8'h40; writedata = 8'h34; memread = 1'b1; memwrite = 1'b1;
    #1;
    tests++; if (memdata !== 8'h12) begin fails++; $display("FAIL rw_prewrite: got %02h expected 12", memdata); end
    @(posedge clk);
    #1 memread = 1'b0; memwrite = 1'b0;
    rd(8'h40, d);
    tests++; if (d !== 8'h34) begin fails++; $display("FAIL rw_postwrite: got %02h expected 34", d); end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] d;
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    tx_ready = 1'b0;
    wr(8'hF0, 8'h11);
    wr(8'hF0, 8'h22);
    wr(8'hF0, 8'h33);
    wr(8'hF0, 8'h44);
    wr(8'hF0, 8'h55);
    rd(8'hF1, d);
    tests++; if (d !== 8'h91) begin fails++; $display("FAIL ovf_status: got %02h expected 91", d); end
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== exp_d[i]) begin
        fails++; $display("FAIL ovf_drain_%0d: got valid=%b data=%02h expected valid=1 data=%02h", i, tx_valid, tx_data, exp_d[i]);
      end
      @(negedge clk);
    end
    #1;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL ovf_drained_valid: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
    rd(8'hF1, d);
    tests++; if (d !== 8'h82) begin fails++; $display("FAIL ovf_status_empty: got %02h expected 82", d); end
    wr(8'hF1, 8'hAA);
    rd(8'hF1, d);
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL ovf_cleared: got %02h expected 02", d); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d;
    logic [7:0] exp_d [4];
    exp_d = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
    tx_ready = 1'b0;
    wr(8'hF0, 8'hA1);
    wr(8'hF0, 8'hA2);
    wr(8'hF0, 8'hA3);
    wr(8'hF0, 8'hA4);
    @(negedge clk);
    adr = 8'hF0; writedata = 8'h66; memwrite = 1'b1; tx_ready = 1'b1;
    #1;
    tests++; if (tx_data !== 8'hA1) begin fails++; $display("FAIL fpp_head_before: got %02h expected a1", tx_data); end
    @(posedge clk);
    #1 memwrite = 1'b0; tx_ready = 1'b0;
    rd(8'hF1, d);
    tests++; if (d !== 8'h11) begin fails++; $display("FAIL fpp_status: got %02h expected 11", d); end
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== exp_d[i]) begin
        fails++; $display("FAIL fpp_drain_%0d: got valid=%b data=%02h expected valid=1 data=%02h", i, tx_valid, tx_data, exp_d[i]);
      end
      @(negedge clk);
    end
    #1;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL fpp_drained_valid: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
    rd(8'hF1, d);
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL fpp_status_end: got %02h expected 02", d); end
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b0;
    wr(8'hF0, 8'h77);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin
        fails++; $display("FAIL backpressure_%0d: got valid=%b data=%02h expected valid=1 data=77", i, tx_valid, tx_data);
      end
    end
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    #1;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL backpressure_pop: got %b expected 0", tx_valid); end
  endtask

  task automatic test_timer();
    logic [7:0] lo;
    logic [7:0] hi;
    do_reset();
    wr(8'hF4, 8'h01);
    repeat (300) @(posedge clk);
    rd(8'hF2, lo);
    rd(8'hF3, hi);
    tests++; if ({hi, lo} !== 16'd300) begin fails++; $display("FAIL timer_300: got %04h expected 012c", {hi, lo}); end
    wr(8'hF4, 8'h03);
    rd(8'hF2, lo);
    tests++; if (lo !== 8'h00) begin fails++; $display("FAIL timer_clear: got %02h expected 00", lo); end
    rd(8'hF2, lo);
    tests++; if (lo !== 8'h01) begin fails++; $display("FAIL timer_after_clear: got %02h expected 01", lo); end
    rd(8'hF4, lo);
    tests++; if (lo !== 8'h01) begin fails++; $display("FAIL timer_ctrl_read: got %02h expected 01", lo); end
    // wrap from 0xFFFF
    @(negedge clk);
    force dut.timer = 16'hFFFF;
    #1 release dut.timer;
    adr = 8'hF2; memread = 1'b1;
    #1;
    tests++; if (memdata !== 8'hFF) begin fails++; $display("FAIL timer_preset: got %02h expected ff", memdata); end
    @(posedge clk);
    #1 memread = 1'b0;
    rd(8'hF2, lo);
    rd(8'hF3, hi);
    tests++; if ({hi, lo} !== 16'h0000) begin fails++; $display("FAIL timer_wrap: got %04h expected 0000", {hi, lo}); end
    wr(8'hF4, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    tx_ready = 1'b0;
    wr(8'h30, 8'hC3);
    wr(8'hF4, 8'h01);
    for (int i = 0; i < 5; i++) wr(8'hF0, 8'(8'hB0 + i));
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    rd(8'hF1, d);
    tests++; if (d !== 8'h8C) begin fails++; $display("FAIL mid_status_pre: got %02h expected 8c", d); end
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL mid_tx_valid: got %b expected 0", tx_valid); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL mid_tx_data: got %02h expected 00", tx_data); end
    adr = 8'hF1; #1;
    tests++; if (memdata !== 8'h02) begin fails++; $display("FAIL mid_status: got %02h expected 02", memdata); end
    adr = 8'hF2; #1;
    tests++; if (memdata !== 8'h00) begin fails++; $display("FAIL mid_timer_lo: got %02h expected 00", memdata); end
    adr = 8'hF4; #1;
    tests++; if (memdata !== 8'h00) begin fails++; $display("FAIL mid_ctrl: got %02h expected 00", memdata); end
    @(negedge clk);
    rst = 1'b1;
    rd(8'h30, d);
    tests++; if (d !== 8'hC3) begin fails++; $display("FAIL mid_ram_30: got %02h expected c3", d); end
    rd(8'h10, d);
    tests++; if (d !== 8'h5A) begin fails++; $display("FAIL mid_ram_10: got %02h expected 5a", d); end
    rd(8'hF2, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL mid_timer_stopped: got %02h expected 00", d); end
  endtask

  initial begin
    rst = 1'b0;
    adr = 8'h00;
    writedata = 8'h00;
    memread = 1'b0;
    memwrite = 1'b0;
    tx_ready = 1'b0;
    test_reset();
    test_ram();
    test_fifo_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_timer();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus.md
Name: mem_bus

Overview:
- Memory/MMIO subsystem directly downstream of the 8-bit multicycle MIPS core. It consumes the core's adr, writedata, memread and memwrite, and produces memdata.
- Provides byte-addressed RAM for instructions and data.
- Provides a memory-mapped output FIFO that drains to an external consumer over a valid/ready handshake.
- Provides a memory-mapped 16-bit cycle timer with a snapshot read.
- Reads are combinational, so the core sees memdata in the same cycle it presents adr. This matches the core's IR/MDR load timing.

Parameters:
- WIDTH, 8: data and address width. MMIO decode assumes 8.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of 2, 2..8.
- TIMER_BITS, 16: timer width. Read as two bytes.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: asynchronous, active-low reset.
- adr, input, WIDTH: byte address from core.
- writedata, input, WIDTH: store data from core.
- memread, input, 1: read strobe; qualifies read side effects only.
- memwrite, input, 1: write strobe; the write commits at posedge.
- memdata, output, WIDTH: read data, combinational from adr.
- tx_data, output, WIDTH: FIFO head byte.
- tx_valid, output, 1: FIFO non-empty.
- tx_ready, input, 1: consumer accepts the head this cycle.

Behaviour:
- Address map:
  - 0x00-0xEF: RAM, 240 bytes.
  - 0xF0 OUT_DATA: write pushes a byte; read returns 0x00.
  - 0xF1 STATUS: bit0 full, bit1 empty, bits4:2 count, bit7 overflow (sticky); other bits 0. A write of any value clears overflow.
  - 0xF2 TIMER_LO: read returns timer[7:0].
  - 0xF3 TIMER_HI: read returns the snapshot register.
  - 0xF4 TIMER_CTRL: write bit0 sets enable, bit1 is clear (self-clearing); read returns {7'b0, enable}.
  - 0xF5-0xFF: read 0x00; writes ignored.
- RAM:
  - Write commits at posedge when memwrite and adr < 0xF0.
  - Contents are not reset; the bench preloads them hierarchically.
- Reads:
  - memdata is driven from adr every cycle, independent of memread.
  - If memread and memwrite are both high, memdata shows the pre-write value and the write commits at the edge.
- Snapshot:
  - At posedge with memread high and adr==0xF2, snapshot <= timer[15:8].
  - Repeated cycles re-capture; the last capture wins.
  - Software reads F2 then F3 for a coherent 16-bit value.
- Timer:
  - Increments by 1 per clk while enable=1.
  - Wraps 0xFFFF -> 0x0000 silently.
  - A clear write forces 0 at the next edge and takes priority over increment.
  - Enable and clear in the same write: the timer is cleared, then counts from the following cycle.
- FIFO:
  - Pop occurs when tx_valid && tx_ready at posedge.
  - Push occurs on memwrite to 0xF0.
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A push while full with no pop drops the byte and sets overflow; count and contents are unchanged.
  - Simultaneous push and pop with count==0 is impossible, since tx_valid=0. The push is accepted.
  - tx_data equals the head entry. It is stable while tx_valid && !tx_ready.
  - tx_valid is never deasserted without a pop.
  - Count never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Reset (rst low, asynchronous):
  - FIFO empty, tx_valid=0, tx_data=0x00.
  - timer=0, enable=0, snapshot=0, overflow=0.
  - RAM unaffected.
  - Reset mid-handshake discards all queued bytes.
  - memdata follows the reset register values immediately, e.g. STATUS reads 0x02.

Decomposition:
- Package mem_bus_pkg holds:
  - MMIO address constants: ADR_OUT_DATA, ADR_STATUS, ADR_TIMER_LO, ADR_TIMER_HI, ADR_TIMER_CTRL, MMIO_BASE=0xF0.
  - STATUS bit indices.
  - TIMER_CTRL bit indices.
- One sub-module: out_fifo.
  - Parameterised by WIDTH and FIFO_DEPTH.
  - Ports: push, push_data, pop, head, count, full, empty, overflow_pulse.
  - mem_bus instantiates it and holds the decode, RAM, timer and sticky overflow.

Test Plan:
- RAM write/read: rst low then high; write 0x5A to 0x10, then 0xA5 to 0xEF; read both in the same cycle adr is presented -> memdata=0x5A and 0xA5. Write to 0xF7 -> read returns 0x00.
- FIFO fill and overflow: hold tx_ready=0; push 0x11, 0x22, 0x33, 0x44, 0x55 to 0xF0.
  - STATUS reads 0x91 (overflow, count=4, full).
  - Raise tx_ready: tx_data sequence is 0x11, 0x22, 0x33, 0x44, then tx_valid=0.
  - STATUS reads 0x82; write 0xF1 -> STATUS reads 0x02.
- Full with simultaneous push/pop: count=4, tx_ready=1, push 0x66 in the same cycle -> accepted. count stays 4, overflow stays 0, and 0x66 drains last.
- Backpressure stability: one queued byte 0x77, tx_ready=0 for 5 cycles -> tx_valid=1 and tx_data=0x77 unchanged.
- Timer: write 0x01 to 0xF4, wait 300 cycles, read 0xF2 then 0xF3 -> the 16-bit value matches the expected count. Write 0x03 -> the next read of 0xF2 is 0x00 or 0x01 per the cycle offset. Force timer to 0xFFFF -> the next cycle reads 0x0000.
- Async reset mid-operation: with 3 bytes queued, timer running and overflow set, pulse rst low between edges -> tx_valid drops immediately, STATUS reads 0x02, timer reads 0, and RAM bytes are retained.
